// File: rtl/handshake_sender_if.sv
// Producer / receiver bundle of the handshake sender.
// master is the sender side, slave is the producer/receiver side.
interface handshake_sender_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          Write;
  logic [15:0]   WriteData;
  logic          Ack;
  logic          Request;
  logic [15:0]   DataOut;
  logic          Full;
  logic          Empty;
  logic [CW-1:0] Count;
  logic          Sent;
  logic          Timeout;
  logic          Error;

  modport master (
    input  Write, WriteData, Ack,
    output Request, DataOut, Full, Empty,
    output Count, Sent, Timeout, Error
  );

  modport slave (
    output Write, WriteData, Ack,
    input  Request, DataOut, Full, Empty,
    input  Count, Sent, Timeout, Error
  );
endinterface

// File: rtl/handshake_sender.sv
// FIFO-buffered four-phase Request/Ack sender
// with per-attempt timeout and bounded retries.
module handshake_sender #(
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 32,
  parameter int MAX_RETRY = 3
) (
  input logic                clk,
  input logic                Reset,
  handshake_sender_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 2);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RELEASE,
    RETRY
  } state_t;

  state_t        state;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] attempt;
  logic [RW-1:0] retry;
  logic          req_q;
  logic [15:0]   data_q;
  logic          sent_q;
  logic          to_q;
  logic          err_q;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = bus.Write && !full;
  assign pop   = (state == IDLE) && !empty;

  assign bus.Request = req_q;
  assign bus.DataOut = data_q;
  assign bus.Full    = full;
  assign bus.Empty   = empty;
  assign bus.Count   = count;
  assign bus.Sent    = sent_q;
  assign bus.Timeout = to_q;
  assign bus.Error   = err_q;

  // Word storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.WriteData;
    end
  end

  // FIFO pointers and occupancy; the in-flight word is not counted.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Transfer FSM with registered handshake outputs and status pulses.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      sent_q  <= 1'b0;
      to_q    <= 1'b0;
      err_q   <= 1'b0;
      attempt <= '0;
      retry   <= '0;
    end else begin
      sent_q <= 1'b0;
      to_q   <= 1'b0;
      if (bus.Write && full) begin
        err_q <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!empty) begin
            data_q  <= mem[rd_ptr];
            req_q   <= 1'b1;
            attempt <= '0;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.Ack) begin
            req_q  <= 1'b0;
            sent_q <= 1'b1;
            retry  <= '0;
            state  <= RELEASE;
          end else if (attempt == TW'(TIMEOUT - 1)) begin
            req_q <= 1'b0;
            to_q  <= 1'b1;
            state <= RETRY;
          end else begin
            attempt <= attempt + TW'(1);
          end
        end
        RETRY: begin
          if (retry < RW'(MAX_RETRY)) begin
            retry   <= retry + RW'(1);
            req_q   <= 1'b1;
            attempt <= '0;
            state   <= REQ;
          end else begin
            err_q <= 1'b1;
            retry <= '0;
            state <= IDLE;
          end
        end
        RELEASE: begin
          if (!bus.Ack) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_handshake_sender.sv
// Directed bench for handshake_sender with a
// queue-based reference model checked every cycle.
module tb_handshake_sender;
  localparam int DEPTH     = 8;
  localparam int TIMEOUT   = 32;
  localparam int MAX_RETRY = 3;

  logic clk;
  logic Reset;

  handshake_sender_if #(.DEPTH(DEPTH)) bus ();

  handshake_sender #(
    .DEPTH    (DEPTH),
    .TIMEOUT  (TIMEOUT),
    .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk  (clk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // reference model: link phases named by the handshake they describe
  typedef enum {L_WAIT, L_OFFER, L_DRAIN, L_GAP} link_t;
  logic [15:0] q[$];
  link_t       link;
  logic        m_req;
  logic [15:0] m_data;
  logic        m_sent;
  logic        m_to;
  logic        m_err;
  int          waited;
  int          attempts;

  logic [15:0] got[$];
  logic [15:0] wq[$];
  int          to_cnt;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    link     = L_WAIT;
    m_req    = 1'b0;
    m_data   = '0;
    m_sent   = 1'b0;
    m_to     = 1'b0;
    m_err    = 1'b0;
    waited   = 0;
    attempts = 0;
  endtask

  // one clock of the specification's rules
  task automatic model_step();
    int n;
    n = q.size();
    m_sent = 1'b0;
    m_to   = 1'b0;
    case (link)
      L_WAIT:
        if (n > 0) begin
          m_data   = q.pop_front();
          m_req    = 1'b1;
          waited   = 0;
          attempts = 1;
          link     = L_OFFER;
        end
      L_OFFER:
        if (bus.Ack) begin
          m_req  = 1'b0;
          m_sent = 1'b1;
          link   = L_DRAIN;
        end else begin
          waited++;
          if (waited == TIMEOUT) begin
            m_req = 1'b0;
            m_to  = 1'b1;
            link  = L_GAP;
          end
        end
      L_GAP:
        if (attempts <= MAX_RETRY) begin
          attempts++;
          waited = 0;
          m_req  = 1'b1;
          link   = L_OFFER;
        end else begin
          m_err = 1'b1;
          link  = L_WAIT;
        end
      L_DRAIN:
        if (!bus.Ack) link = L_WAIT;
      default: link = L_WAIT;
    endcase
    if (bus.Write) begin
      if (n == DEPTH) m_err = 1'b1;
      else q.push_back(bus.WriteData);
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk or posedge Reset);
      if (Reset) model_reset();
      else model_step();
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      if (!Reset) begin
        chk("Request", 32'(bus.Request), 32'(m_req));
        chk("DataOut", 32'(bus.DataOut), 32'(m_data));
        chk("Count", 32'(bus.Count), 32'(q.size()));
        chk("Full", 32'(bus.Full), 32'(q.size() == DEPTH));
        chk("Empty", 32'(bus.Empty), 32'(q.size() == 0));
        chk("Sent", 32'(bus.Sent), 32'(m_sent));
        chk("Timeout", 32'(bus.Timeout), 32'(m_to));
        chk("Error", 32'(bus.Error), 32'(m_err));
        if (bus.Sent) got.push_back(bus.DataOut);
        if (bus.Timeout) to_cnt++;
      end
    end
  endtask

  task automatic wr(logic [15:0] d);
    bus.WriteData = d;
    bus.Write     = 1'b1;
    @(negedge clk);
    bus.Write     = 1'b0;
  endtask

  task automatic respond();
    int t;
    t = 0;
    while (!bus.Request && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("resp_wait", 0, 1);
    bus.Ack = 1'b1;
    @(negedge clk);
    bus.Ack = 1'b0;
  endtask

  initial begin
    logic [15:0] e2[9];
    int t;
    int base;
    e2 = '{16'h00FF, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
           16'h0005, 16'h0006, 16'h0007, 16'h0008};
    checks = 0;
    errors = 0;
    to_cnt = 0;
    Reset = 1'b1;
    bus.Write = 1'b0;
    bus.WriteData = '0;
    bus.Ack = 1'b0;
    model_reset();
    fork
      model_loop();
      compare_loop();
    join_none

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_Request", 32'(bus.Request), 0);
    chk("rst_DataOut", 32'(bus.DataOut), 0);
    chk("rst_Count", 32'(bus.Count), 0);
    chk("rst_Empty", 32'(bus.Empty), 1);
    chk("rst_Full", 32'(bus.Full), 0);
    chk("rst_Error", 32'(bus.Error), 0);
    Reset = 1'b0;
    @(negedge clk);

    // single word, two-edge latency, ack one cycle later
    wr(16'hA5A5);
    @(negedge clk);
    chk("t1_Request", 32'(bus.Request), 1);
    chk("t1_DataOut", 32'(bus.DataOut), 32'hA5A5);
    bus.Ack = 1'b1;
    @(negedge clk);
    chk("t1_Sent", 32'(bus.Sent), 1);
    bus.Ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("t1_Count", 32'(bus.Count), 0);
    chk("t1_nsent", got.size(), 1);
    got.delete();

    // overflow with one word in flight
    wr(16'h00FF);
    @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      wr(16'(i));
      if (i == 8) chk("t2_Full", 32'(bus.Full), 1);
    end
    chk("t2_Error", 32'(bus.Error), 1);
    chk("t2_Count", 32'(bus.Count), 8);
    repeat (9) respond();
    repeat (3) @(negedge clk);
    chk("t2_nsent", got.size(), 9);
    for (int i = 0; i < 9 && i < got.size(); i++)
      chk("t2_order", 32'(got[i]), 32'(e2[i]));
    got.delete();

    // concurrent producer and receiver
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [15:0] w;
          w = 16'($urandom);
          wq.push_back(w);
          wr(w);
          repeat ($urandom_range(2, 5)) @(negedge clk);
        end
      end
      begin
        repeat (20) respond();
      end
    join
    repeat (3) @(negedge clk);
    chk("t4_nsent", got.size(), 20);
    for (int i = 0; i < 20 && i < got.size(); i++)
      chk("t4_order", 32'(got[i]), 32'(wq[i]));
    got.delete();

    // silent receiver: timeouts, retries, drop
    Reset = 1'b1;
    @(negedge clk);
    Reset = 1'b0;
    base = to_cnt;
    wr(16'h1111);
    wr(16'h2222);
    t = 0;
    while (!bus.Error && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) chk("t3_err_wait", 0, 1);
    chk("t3_timeouts", to_cnt - base, 4);
    chk("t3_Request_low", 32'(bus.Request), 0);
    t = 0;
    while (!bus.Request && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("t3_next", 32'(bus.DataOut), 32'h2222);
    // ack lands on the edge that would expire the attempt
    repeat (TIMEOUT - 1) @(negedge clk);
    bus.Ack = 1'b1;
    @(negedge clk);
    chk("t6_ack_wins_Sent", 32'(bus.Sent), 1);
    chk("t6_ack_wins_Timeout", 32'(bus.Timeout), 0);
    bus.Ack = 1'b0;
    @(negedge clk);

    // write and pop on the same edge with three queued
    wr(16'h0061);
    @(negedge clk);
    wr(16'h0062);
    wr(16'h0063);
    wr(16'h0064);
    chk("t6_Count_pre", 32'(bus.Count), 3);
    bus.Ack = 1'b1;
    @(negedge clk);
    bus.Ack = 1'b0;
    @(negedge clk);
    wr(16'h0065);
    chk("t6_Count_post", 32'(bus.Count), 3);
    chk("t6_DataOut", 32'(bus.DataOut), 32'h0062);
    repeat (4) respond();
    repeat (3) @(negedge clk);

    // asynchronous reset during a transfer
    wr(16'h0071);
    wr(16'h0072);
    wr(16'h0073);
    chk("t5_Request_pre", 32'(bus.Request), 1);
    @(posedge clk);
    #2 Reset = 1'b1;
    #1;
    chk("t5_Request", 32'(bus.Request), 0);
    chk("t5_DataOut", 32'(bus.DataOut), 0);
    chk("t5_Count", 32'(bus.Count), 0);
    chk("t5_Error", 32'(bus.Error), 0);
    @(negedge clk);
    Reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_Empty", 32'(bus.Empty), 1);
    chk("t5_Request_post", 32'(bus.Request), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
